// File: rtl/regfile_port_ctrl_pkg.sv
// Shared types and default sizes for the register-file port controller.
package regfile_ctrl_pkg;

    localparam int RF_NREGS = 32;
    localparam int RF_XLEN  = 32;
    localparam int RF_AW    = 5;

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        DBG_ACC,
        RSP
    } state_t;

    typedef struct packed {
        logic               write;
        logic [RF_AW-1:0]   addr;
        logic [RF_XLEN-1:0] wdata;
    } dbg_req_t;

endpackage

// File: rtl/regfile_port_ctrl_if.sv
// Debug request/response channel into the register-file port controller.
interface regfile_port_ctrl_if #(
    parameter int AW   = 5,
    parameter int XLEN = 32
) ();

    logic            dbg_req_valid;
    logic            dbg_req_ready;
    logic            dbg_req_write;
    logic [AW-1:0]   dbg_req_addr;
    logic [XLEN-1:0] dbg_req_wdata;
    logic            dbg_rsp_valid;
    logic            dbg_rsp_ready;
    logic [XLEN-1:0] dbg_rsp_rdata;

    modport master (
        output dbg_req_valid, dbg_req_write, dbg_req_addr, dbg_req_wdata, dbg_rsp_ready,
        input  dbg_req_ready, dbg_rsp_valid, dbg_rsp_rdata
    );

    modport slave (
        input  dbg_req_valid, dbg_req_write, dbg_req_addr, dbg_req_wdata, dbg_rsp_ready,
        output dbg_req_ready, dbg_rsp_valid, dbg_rsp_rdata
    );

endinterface

// File: rtl/regfile_port_ctrl.sv
// Owns the register file write port: clears the file after reset, then arbitrates
// between core writeback and single-cycle debug accesses that stall the core.
module regfile_port_ctrl
    import regfile_ctrl_pkg::*;
#(
    parameter int NREGS = RF_NREGS,
    parameter int XLEN  = RF_XLEN,
    parameter int AW    = RF_AW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            core_we,
    input  logic [AW-1:0]   core_rd,
    input  logic [XLEN-1:0] core_wdata,
    input  logic [AW-1:0]   core_rs2,
    output logic            core_stall,
    output logic            init_done,
    regfile_port_ctrl_if.slave dbg,
    output logic            rf_we,
    output logic [AW-1:0]   rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic [AW-1:0]   rf_rs2,
    input  logic [XLEN-1:0] rf_rdata2
);

    state_t          state_q;
    state_t          state_d;
    logic [AW-1:0]   cnt_q;
    logic [XLEN-1:0] rdata_q;
    dbg_req_t        req_q;
    logic            core_wr;
    logic            req_fire;

    assign core_wr  = core_we && (core_rd != '0);
    assign req_fire = dbg.dbg_req_valid && dbg.dbg_req_ready;

    // Clear counter, FSM state and response register share one reset domain
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= INIT;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == INIT && cnt_q != AW'(NREGS - 1)) begin
                cnt_q <= cnt_q + AW'(1);
            end
            if (state_q == DBG_ACC) begin
                rdata_q <= (req_q.write || req_q.addr == '0) ? '0 : rf_rdata2;
            end
        end
    end

    // Request payload is pure data and only meaningful once accepted
    always_ff @(posedge clk) begin
        if (req_fire) begin
            req_q.write <= dbg.dbg_req_write;
            req_q.addr  <= dbg.dbg_req_addr;
            req_q.wdata <= dbg.dbg_req_wdata;
        end
    end

    always_comb begin
        state_d           = state_q;
        rf_we             = 1'b0;
        rf_waddr          = core_rd;
        rf_wdata          = core_wdata;
        rf_rs2            = core_rs2;
        core_stall        = 1'b1;
        init_done         = 1'b1;
        dbg.dbg_req_ready = 1'b0;
        dbg.dbg_rsp_valid = 1'b0;
        unique case (state_q)
            INIT: begin
                init_done = 1'b0;
                rf_we     = rst;
                rf_waddr  = cnt_q;
                rf_wdata  = '0;
                if (cnt_q == AW'(NREGS - 1)) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                rf_we             = core_wr;
                core_stall        = 1'b0;
                dbg.dbg_req_ready = 1'b1;
                if (req_fire) begin
                    state_d = DBG_ACC;
                end
            end
            DBG_ACC: begin
                // Core is frozen this cycle, so the debug access owns both ports
                rf_we    = req_q.write && (req_q.addr != '0);
                rf_waddr = req_q.addr;
                rf_wdata = req_q.wdata;
                rf_rs2   = req_q.addr;
                state_d  = RSP;
            end
            RSP: begin
                rf_we             = core_wr;
                core_stall        = 1'b0;
                dbg.dbg_rsp_valid = 1'b1;
                if (dbg.dbg_rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = INIT;
        endcase
    end

    assign dbg.dbg_rsp_rdata = rdata_q;

endmodule

// File: tb/tb_regfile_port_ctrl.sv
// Bench for regfile_port_ctrl with a behavioural register file and a debug
// response scoreboard.
module tb_regfile_port_ctrl;

    localparam int NREGS = 32;
    localparam int XLEN  = 32;
    localparam int AW    = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            core_we;
    logic [AW-1:0]   core_rd;
    logic [XLEN-1:0] core_wdata;
    logic [AW-1:0]   core_rs2;
    logic            core_stall;
    logic            init_done;
    logic            rf_we;
    logic [AW-1:0]   rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic [AW-1:0]   rf_rs2;
    logic [XLEN-1:0] rf_rdata2;

    logic [XLEN-1:0] mem    [NREGS];
    logic [XLEN-1:0] exp_rf [NREGS];
    logic [XLEN-1:0] sb_q   [$];
    int n_tests = 0;
    int n_fail  = 0;

    regfile_port_ctrl_if #(.AW(AW), .XLEN(XLEN)) dbg ();

    regfile_port_ctrl #(.NREGS(NREGS), .XLEN(XLEN), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .core_we    (core_we),
        .core_rd    (core_rd),
        .core_wdata (core_wdata),
        .core_rs2   (core_rs2),
        .core_stall (core_stall),
        .init_done  (init_done),
        .dbg        (dbg),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .rf_rs2     (rf_rs2),
        .rf_rdata2  (rf_rdata2)
    );

    always #5 clk = ~clk;

    // Behavioural register file: one write port, combinational second read port
    always @(posedge clk) begin
        if (rf_we) mem[rf_waddr] <= rf_wdata;
    end
    assign rf_rdata2 = mem[rf_rs2];

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_clear();
        for (int i = 0; i < NREGS; i++) begin
            chk_eq($sformatf("clr_we[%0d]", i), 32'(rf_we), 32'd1);
            chk_eq($sformatf("clr_addr[%0d]", i), 32'(rf_waddr), 32'(i));
            chk_eq($sformatf("clr_data[%0d]", i), rf_wdata, 32'd0);
            chk_eq($sformatf("clr_done[%0d]", i), 32'(init_done), 32'd0);
            @(negedge clk); #1;
        end
        chk_eq("init_done", 32'(init_done), 32'd1);
        chk_eq("init_stall", 32'(core_stall), 32'd0);
        for (int i = 0; i < NREGS; i++) begin
            exp_rf[i] = '0;
            chk_eq($sformatf("clr_mem[%0d]", i), mem[i], 32'd0);
        end
    endtask

    // One full debug transaction; hold = cycles of response backpressure
    task automatic dbg_access(input logic wr, input logic [AW-1:0] addr,
                              input logic [XLEN-1:0] wdata, input int hold);
        logic [XLEN-1:0] expv;
        chk_eq("acc_ready", 32'(dbg.dbg_req_ready), 32'd1);
        dbg.dbg_req_valid = 1'b1;
        dbg.dbg_req_write = wr;
        dbg.dbg_req_addr  = addr;
        dbg.dbg_req_wdata = wdata;
        sb_q.push_back((wr || addr == '0) ? '0 : exp_rf[addr]);
        if (wr && addr != '0) exp_rf[addr] = wdata;
        @(negedge clk); #1;
        dbg.dbg_req_valid = 1'b0;
        core_we = 1'b1; core_rd = addr; core_wdata = 32'h1111_1111;
        #1;
        chk_eq("dacc_stall", 32'(core_stall), 32'd1);
        chk_eq("dacc_ready", 32'(dbg.dbg_req_ready), 32'd0);
        chk_eq("dacc_rvalid", 32'(dbg.dbg_rsp_valid), 32'd0);
        chk_eq("dacc_we", 32'(rf_we), 32'(wr && addr != '0));
        if (wr) chk_eq("dacc_waddr", 32'(rf_waddr), 32'(addr));
        else    chk_eq("dacc_rs2", 32'(rf_rs2), 32'(addr));
        @(negedge clk); #1;
        core_we = 1'b0;
        #1;
        chk_eq("rsp_valid", 32'(dbg.dbg_rsp_valid), 32'd1);
        chk_eq("rsp_stall", 32'(core_stall), 32'd0);
        expv = (sb_q.size() > 0) ? sb_q[0] : 32'hxxxx_xxxx;
        for (int k = 0; k < hold; k++) begin
            chk_eq("bp_rdata", dbg.dbg_rsp_rdata, expv);
            chk_eq("bp_valid", 32'(dbg.dbg_rsp_valid), 32'd1);
            chk_eq("bp_ready", 32'(dbg.dbg_req_ready), 32'd0);
            @(negedge clk); #1;
        end
        dbg.dbg_rsp_ready = 1'b1;
        #1;
        if (sb_q.size() > 0) expv = sb_q.pop_front();
        chk_eq($sformatf("rsp_rdata_a%0d", addr), dbg.dbg_rsp_rdata, expv);
        @(negedge clk); #1;
        dbg.dbg_rsp_ready = 1'b0;
        #1;
        chk_eq("post_rvalid", 32'(dbg.dbg_rsp_valid), 32'd0);
        chk_eq("post_ready", 32'(dbg.dbg_req_ready), 32'd1);
        chk_eq($sformatf("post_mem%0d", addr), mem[addr], exp_rf[addr]);
    endtask

    initial begin
        rst = 1'b0;
        core_we = 1'b0; core_rd = '0; core_wdata = '0; core_rs2 = '0;
        dbg.dbg_req_valid = 1'b0; dbg.dbg_req_write = 1'b0;
        dbg.dbg_req_addr = '0; dbg.dbg_req_wdata = '0; dbg.dbg_rsp_ready = 1'b0;
        for (int i = 0; i < NREGS; i++) mem[i] = 32'hDEAD_BEEF;
        repeat (3) @(negedge clk);
        #1;
        chk_eq("rst_we", 32'(rf_we), 32'd0);
        chk_eq("rst_stall", 32'(core_stall), 32'd1);
        chk_eq("rst_done", 32'(init_done), 32'd0);
        chk_eq("rst_ready", 32'(dbg.dbg_req_ready), 32'd0);
        chk_eq("rst_rvalid", 32'(dbg.dbg_rsp_valid), 32'd0);
        chk_eq("rst_rdata", dbg.dbg_rsp_rdata, 32'd0);

        @(negedge clk);
        rst = 1'b1;
        #1;
        run_clear();

        // Core writeback, including the discarded x0 write
        core_we = 1'b1; core_rd = 5'd5; core_wdata = 32'h1234_5678;
        #1;
        chk_eq("core_we5", 32'(rf_we), 32'd1);
        exp_rf[5] = 32'h1234_5678;
        @(negedge clk); #1;
        chk_eq("core_mem5", mem[5], exp_rf[5]);
        core_rd = 5'd0; core_wdata = 32'hFFFF_FFFF;
        #1;
        chk_eq("core_we0", 32'(rf_we), 32'd0);
        @(negedge clk); #1;
        core_we = 1'b0;
        chk_eq("core_mem0", mem[0], 32'd0);

        dbg_access(1'b1, 5'd7, 32'hA5A5_A5A5, 0);
        dbg_access(1'b0, 5'd7, 32'h0, 5);
        dbg_access(1'b0, 5'd0, 32'h0, 0);
        dbg_access(1'b0, 5'd5, 32'h0, 2);
        dbg_access(1'b1, 5'd0, 32'h5555_AAAA, 1);
        dbg_access(1'b0, 5'd0, 32'h0, 0);

        // Reset asserted while a debug write is in DBG_ACC
        dbg.dbg_req_valid = 1'b1; dbg.dbg_req_write = 1'b1;
        dbg.dbg_req_addr = 5'd9; dbg.dbg_req_wdata = 32'hCAFE_F00D;
        @(negedge clk); #1;
        dbg.dbg_req_valid = 1'b0;
        chk_eq("mid_stall_pre", 32'(core_stall), 32'd1);
        rst = 1'b0;
        #1;
        chk_eq("mid_we", 32'(rf_we), 32'd0);
        chk_eq("mid_stall", 32'(core_stall), 32'd1);
        chk_eq("mid_done", 32'(init_done), 32'd0);
        chk_eq("mid_rvalid", 32'(dbg.dbg_rsp_valid), 32'd0);
        chk_eq("mid_rdata", dbg.dbg_rsp_rdata, 32'd0);
        @(negedge clk); #1;
        chk_eq("mid_mem9", mem[9], 32'd0);
        rst = 1'b1;
        #1;
        run_clear();
        chk_eq("mid_no_rsp", 32'(dbg.dbg_rsp_valid), 32'd0);
        chk_eq("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
